// File: rtl/dcache_pkg.sv
// Shared types, field widths and address-slicing helpers for the direct-mapped
// write-back data cache.
package dcache_pkg;

    localparam int OFFSET_W   = 5;
    localparam int INDEX_W    = 5;
    localparam int TAG_W      = 22;
    localparam int WORD_W     = 32;
    localparam int WORD_SEL_W = 3;
    localparam int BYTE_SEL_W = 2;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE
    } state_t;

    function automatic logic [INDEX_W-1:0] addr_index(input logic [31:0] addr);
        return addr[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] addr);
        return addr[OFFSET_W+INDEX_W +: TAG_W];
    endfunction

    function automatic logic [WORD_SEL_W-1:0] addr_word(input logic [31:0] addr);
        return addr[BYTE_SEL_W +: WORD_SEL_W];
    endfunction

    // Rebuild a line-aligned byte address from its stored tag and set index.
    function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag,
                                              input logic [INDEX_W-1:0] index);
        return {tag, index, {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage for the cache: one port, combinational read,
// whole-line refill write and single-word store write.
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 32,
    parameter int LINE_W    = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [INDEX_W-1:0]    index,
    input  logic                  line_we,
    input  logic [LINE_W-1:0]     line_wdata,
    input  logic [TAG_W-1:0]      line_tag,
    input  logic                  word_we,
    input  logic [WORD_SEL_W-1:0] word_sel,
    input  logic [WORD_W-1:0]     word_wdata,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [LINE_W-1:0]     rd_line
);

    localparam int WORDS = LINE_W / WORD_W;

    logic [NUM_LINES-1:0] valid_reg;
    logic [NUM_LINES-1:0] dirty_reg;
    logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
    logic [LINE_W-1:0]    data_mem [NUM_LINES];
    logic [LINE_W-1:0]    merged_line;

    assign rd_valid = valid_reg[index];
    assign rd_dirty = dirty_reg[index];
    assign rd_tag   = tag_mem[index];
    assign rd_line  = data_mem[index];

    // A store replaces one word of the resident line and keeps the rest.
    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_merge
            assign merged_line[gi*WORD_W +: WORD_W] =
                (word_sel == WORD_SEL_W'(gi)) ? word_wdata : rd_line[gi*WORD_W +: WORD_W];
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_reg <= '0;
            dirty_reg <= '0;
        end else if (line_we) begin
            valid_reg[index] <= 1'b1;
            dirty_reg[index] <= 1'b0;
        end else if (word_we) begin
            dirty_reg[index] <= 1'b1;
        end
    end

    // Contents carry no reset; a reset cycle simply blocks any write.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (line_we) begin
                tag_mem[index]  <= line_tag;
                data_mem[index] <= line_wdata;
            end else if (word_we) begin
                data_mem[index] <= merged_line;
            end
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller: serves MEM
// stage loads/stores and runs victim writeback plus line refill on a miss.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 32,
    parameter int LINE_W    = 256,
    parameter int ADDR_W    = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cpu_req_i,
    input  logic              cpu_write_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [31:0]       cpu_data_i,
    output logic [31:0]       cpu_data_o,
    output logic              cpu_stall_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i
);

    localparam int WORDS = LINE_W / WORD_W;

    state_t              state_reg, state_next;
    logic                mem_enable_reg, mem_enable_next;
    logic                mem_write_reg, mem_write_next;
    logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
    logic [LINE_W-1:0]   mem_data_reg, mem_data_next;

    logic [INDEX_W-1:0]    req_index;
    logic [TAG_W-1:0]      req_tag;
    logic [WORD_SEL_W-1:0] req_word;
    logic                  rd_valid;
    logic                  rd_dirty;
    logic [TAG_W-1:0]      rd_tag;
    logic [LINE_W-1:0]     rd_line;
    logic [WORD_W-1:0]     line_words [WORDS];
    logic                  hit;
    logic                  in_idle;
    logic                  line_we;
    logic                  word_we;
    logic                  unused_byte_sel;

    assign req_index       = addr_index(cpu_addr_i);
    assign req_tag         = addr_tag(cpu_addr_i);
    assign req_word        = addr_word(cpu_addr_i);
    assign unused_byte_sel = ^cpu_addr_i[BYTE_SEL_W-1:0];

    dcache_sram #(
        .NUM_LINES (NUM_LINES),
        .LINE_W    (LINE_W)
    ) u_sram (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .index      (req_index),
        .line_we    (line_we),
        .line_wdata (mem_data_i),
        .line_tag   (req_tag),
        .word_we    (word_we),
        .word_sel   (req_word),
        .word_wdata (cpu_data_i),
        .rd_valid   (rd_valid),
        .rd_dirty   (rd_dirty),
        .rd_tag     (rd_tag),
        .rd_line    (rd_line)
    );

    generate
        for (genvar gi = 0; gi < WORDS; gi++) begin : g_words
            assign line_words[gi] = rd_line[gi*WORD_W +: WORD_W];
        end
    endgenerate

    assign hit         = rd_valid && (rd_tag == req_tag);
    assign in_idle     = (state_reg == IDLE);
    assign cpu_stall_o = cpu_req_i && (!in_idle || !hit);
    assign cpu_data_o  = (cpu_req_i && in_idle && hit) ? line_words[req_word] : '0;
    assign word_we     = cpu_req_i && cpu_write_i && in_idle && hit;

    assign mem_enable_o = mem_enable_reg;
    assign mem_write_o  = mem_write_reg;
    assign mem_addr_o   = mem_addr_reg;
    assign mem_data_o   = mem_data_reg;

    always_comb begin
        state_next      = state_reg;
        mem_enable_next = mem_enable_reg;
        mem_write_next  = mem_write_reg;
        mem_addr_next   = mem_addr_reg;
        mem_data_next   = mem_data_reg;
        line_we         = 1'b0;

        case (state_reg)
            IDLE: begin
                if (cpu_req_i && !hit) begin
                    mem_enable_next = 1'b1;
                    if (rd_valid && rd_dirty) begin
                        state_next     = WRITEBACK;
                        mem_write_next = 1'b1;
                        mem_addr_next  = line_addr(rd_tag, req_index);
                        mem_data_next  = rd_line;
                    end else begin
                        state_next     = ALLOCATE;
                        mem_write_next = 1'b0;
                        mem_addr_next  = line_addr(req_tag, req_index);
                    end
                end
            end
            // The read request follows the writeback back-to-back, enable stays high.
            WRITEBACK: begin
                if (mem_ack_i) begin
                    state_next     = ALLOCATE;
                    mem_write_next = 1'b0;
                    mem_addr_next  = line_addr(req_tag, req_index);
                end
            end
            ALLOCATE: begin
                if (mem_ack_i) begin
                    state_next      = IDLE;
                    mem_enable_next = 1'b0;
                    line_we         = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg      <= IDLE;
            mem_enable_reg <= 1'b0;
            mem_write_reg  <= 1'b0;
            mem_addr_reg   <= '0;
            mem_data_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            mem_enable_reg <= mem_enable_next;
            mem_write_reg  <= mem_write_next;
            mem_addr_reg   <= mem_addr_next;
            mem_data_reg   <= mem_data_next;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: a flat word-memory model plus a
// per-set residency model predict load data, stall lengths and memory traffic.
module tb_dcache_ctrl;

    localparam int L = 10;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         cpu_req_i;
    logic         cpu_write_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;

    always #5 clk_i = ~clk_i;

    dcache_ctrl #(
        .NUM_LINES (32),
        .LINE_W    (256),
        .ADDR_W    (32)
    ) u_dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cpu_req_i    (cpu_req_i),
        .cpu_write_i  (cpu_write_i),
        .cpu_addr_i   (cpu_addr_i),
        .cpu_data_i   (cpu_data_i),
        .cpu_data_o   (cpu_data_o),
        .cpu_stall_o  (cpu_stall_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_data_i   (mem_data_i),
        .mem_ack_i    (mem_ack_i)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [255:0] backing [int unsigned];   // off-chip memory lines
    logic [31:0]  overlay [int unsigned];   // stores accepted by the cache, word address keyed

    function automatic logic [255:0] get_line(input logic [31:0] la);
        logic [255:0] l;
        if (backing.exists(la)) return backing[la];
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = (la + 32'(w*4)) ^ 32'hA5A5_0000;
        return l;
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] addr);
        logic [255:0] l;
        logic [31:0]  wa;
        wa = {addr[31:2], 2'b00};
        if (overlay.exists(wa)) return overlay[wa];
        l = get_line({addr[31:5], 5'b0});
        return l[addr[4:2]*32 +: 32];
    endfunction

    function automatic logic [255:0] model_line(input logic [31:0] la);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) l[w*32 +: 32] = model_word(la + 32'(w*4));
        return l;
    endfunction

    // Per-set residency used to predict hit / clean miss / dirty miss.
    logic [31:0] set_line  [32];
    bit          set_valid [32];
    bit          set_dirty [32];

    // ---------------- memory responder ----------------
    typedef struct packed { logic wr; logic [31:0] addr; } txn_t;
    txn_t         txn_q[$];
    bit           mem_auto = 1'b1;
    bit           man_ack  = 1'b0;
    logic [255:0] man_data = '0;
    int           mem_count = 0;
    bit           recover = 1'b0;
    bit           auto_ack;

    // Acks after L cycles of a held request; one idle cycle follows every ack.
    initial begin
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        forever begin
            @(negedge clk_i);
            auto_ack = 1'b0;
            if (rst_i || !mem_auto) begin
                mem_count = 0;
                recover   = 1'b0;
            end else if (recover) begin
                recover   = 1'b0;
                mem_count = 0;
            end else if (mem_enable_o) begin
                mem_count++;
                if (mem_count == L) begin
                    auto_ack  = 1'b1;
                    mem_count = 0;
                    recover   = 1'b1;
                    txn_q.push_back({mem_write_o, mem_addr_o});
                    if (mem_write_o) begin
                        check("wb_line", mem_data_o, model_line(mem_addr_o));
                        backing[mem_addr_o] = mem_data_o;
                    end else begin
                        mem_data_i = get_line(mem_addr_o);
                    end
                end
            end else begin
                mem_count = 0;
            end
            if (man_ack) begin
                auto_ack   = 1'b1;
                mem_data_i = man_data;
            end
            mem_ack_i = auto_ack;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                if (cpu_req_i && !cpu_stall_o) begin
                    if (cpu_write_i) overlay[{cpu_addr_i[31:2], 2'b00}] = cpu_data_i;
                    else check("load_data", cpu_data_o, model_word(cpu_addr_i));
                end
                if (!cpu_req_i) check("no_req_stall", cpu_stall_o, 1'b0);
                if (mem_enable_o) check("mem_addr_align", mem_addr_o[4:0], 5'd0);
            end
        end
    end

    // ---------------- transaction driver ----------------
    task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output int stalls, output logic [31:0] rdata);
        int          idx;
        logic [31:0] la;
        int          exp_stall;
        bit          was_hit;
        bit          done;
        txn_t        exp_q[$];
        idx     = int'(addr[9:5]);
        la      = {addr[31:5], 5'b0};
        was_hit = set_valid[idx] && (set_line[idx] == la);
        if (was_hit) begin
            exp_stall = 0;
        end else if (set_valid[idx] && set_dirty[idx]) begin
            exp_stall = 2*L + 2;
            exp_q.push_back({1'b1, set_line[idx]});
            exp_q.push_back({1'b0, la});
        end else begin
            exp_stall = L + 1;
            exp_q.push_back({1'b0, la});
        end
        txn_q.delete();
        @(posedge clk_i); #1;
        cpu_req_i   = 1'b1;
        cpu_write_i = wr;
        cpu_addr_i  = addr;
        cpu_data_i  = wdata;
        stalls = 0;
        done   = 1'b0;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk_i);
            if (!cpu_stall_o) begin
                done = 1'b1;
                break;
            end
            stalls++;
        end
        rdata = cpu_data_o;
        @(posedge clk_i); #1;
        cpu_req_i   = 1'b0;
        cpu_write_i = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL stall_timeout: addr %08h still stalled after 500 cycles", addr);
        end
        check("stall_cycles", stalls, exp_stall);
        check("mem_txn_count", txn_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < txn_q.size(); i++)
            check("mem_txn", txn_q[i], exp_q[i]);
        set_dirty[idx] = (was_hit ? set_dirty[idx] : 1'b0) | wr;
        set_line[idx]  = la;
        set_valid[idx] = 1'b1;
        $display("txn %s addr=%08h wdata=%08h rdata=%08h stall=%0d mem_txns=%0d",
                 wr ? "ST" : "LD", addr, wdata, rdata, stalls, txn_q.size());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int           st;
        logic [31:0]  rd;
        logic [255:0] l;
        rst_i       = 1'b1;
        cpu_req_i   = 1'b0;
        cpu_write_i = 1'b0;
        cpu_addr_i  = '0;
        cpu_data_i  = '0;
        for (int i = 0; i < 32; i++) begin
            set_valid[i] = 1'b0;
            set_dirty[i] = 1'b0;
            set_line[i]  = '0;
        end
        l = get_line(32'h40);
        l[31:0]  = 32'hDEAD_BEEF;
        l[95:64] = 32'hDEAD_BEEF;
        backing[32'h40] = l;

        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("rst_stall", cpu_stall_o, 1'b0);
        check("rst_cpu_data", cpu_data_o, 32'h0);
        check("rst_mem_enable", mem_enable_o, 1'b0);
        check("rst_mem_write", mem_write_o, 1'b0);
        check("rst_mem_addr", mem_addr_o, 32'h0);
        check("rst_mem_data", mem_data_o, 256'h0);
        @(posedge clk_i); #1;
        rst_i = 1'b0;

        // Cold load, clean miss
        access(1'b0, 32'h0000_0040, 32'h0, st, rd);
        check("t1_stall", st, 11);
        check("t1_data", rd, 32'hDEAD_BEEF);
        check("t1_mem_read", txn_q[0], {1'b0, 32'h0000_0040});
        access(1'b0, 32'h0000_0048, 32'h0, st, rd);
        check("t1_word2", rd, 32'hDEAD_BEEF);

        // Store hit then load hit
        access(1'b1, 32'h0000_0044, 32'h1234_5678, st, rd);
        check("t2_store_stall", st, 0);
        access(1'b0, 32'h0000_0044, 32'h0, st, rd);
        check("t2_load_stall", st, 0);
        check("t2_load_data", rd, 32'h1234_5678);

        // Unqualified write inputs must be ignored
        @(posedge clk_i); #1;
        cpu_write_i = 1'b1;
        cpu_addr_i  = 32'h0000_0044;
        cpu_data_i  = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk_i);
        #1;
        cpu_write_i = 1'b0;
        access(1'b0, 32'h0000_0044, 32'h0, st, rd);
        check("t2_no_req_write", rd, 32'h1234_5678);

        // Conflict miss on dirty line
        access(1'b0, 32'h0000_0440, 32'h0, st, rd);
        check("t3_stall", st, 22);
        check("t3_wb", txn_q[0], {1'b1, 32'h0000_0040});
        check("t3_read", txn_q[1], {1'b0, 32'h0000_0440});
        l = backing[32'h40];
        check("t3_wb_word1", l[63:32], 32'h1234_5678);
        check("t3_data", rd, 32'hA5A5_0440);

        // Store miss to a clean set
        access(1'b1, 32'h0000_0080, 32'hCAFE_F00D, st, rd);
        check("t4_store_stall", st, 11);
        access(1'b0, 32'h0000_0080, 32'h0, st, rd);
        check("t4_load_data", rd, 32'hCAFE_F00D);
        access(1'b0, 32'h0000_0480, 32'h0, st, rd);
        check("t4_dirty_evict_stall", st, 22);
        check("t4_wb", txn_q[0], {1'b1, 32'h0000_0080});

        // Reset during writeback, ack arrives two cycles later
        access(1'b1, 32'h0000_0440, 32'h0BAD_C0DE, st, rd);
        mem_auto = 1'b0;
        @(posedge clk_i); #1;
        cpu_req_i  = 1'b1;
        cpu_addr_i = 32'h0000_0840;
        @(negedge clk_i);
        check("t5_miss_stall", cpu_stall_o, 1'b1);
        repeat (2) @(negedge clk_i);
        check("t5_wb_enable", mem_enable_o, 1'b1);
        check("t5_wb_write", mem_write_o, 1'b1);
        check("t5_wb_addr", mem_addr_o, 32'h0000_0440);
        l = mem_data_o;
        check("t5_wb_word0", l[31:0], 32'h0BAD_C0DE);
        @(posedge clk_i); #1;
        rst_i     = 1'b1;
        cpu_req_i = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("t5_enable_after_rst", mem_enable_o, 1'b0);
        @(posedge clk_i); #1;
        man_data = '1;
        man_ack  = 1'b1;
        @(posedge clk_i); #1;
        man_ack = 1'b0;
        @(negedge clk_i);
        check("t5_late_ack_enable", mem_enable_o, 1'b0);
        for (int i = 0; i < 32; i++) set_valid[i] = 1'b0;
        overlay.delete();
        mem_auto = 1'b1;
        access(1'b0, 32'h0000_0040, 32'h0, st, rd);
        check("t5_reload_stall", st, 11);
        check("t5_reload_data", rd, 32'hDEAD_BEEF);
        access(1'b0, 32'h0000_0440, 32'h0, st, rd);
        check("t5_lost_dirty_stall", st, 11);
        check("t5_lost_dirty_data", rd, 32'hA5A5_0440);

        // Stray ack while idle
        @(posedge clk_i); #1;
        man_data = '1;
        man_ack  = 1'b1;
        @(posedge clk_i); #1;
        man_ack = 1'b0;
        @(negedge clk_i);
        check("t6_stall", cpu_stall_o, 1'b0);
        check("t6_enable", mem_enable_o, 1'b0);
        access(1'b0, 32'h0000_0440, 32'h0, st, rd);
        check("t6_hit_stall", st, 0);
        check("t6_data", rd, 32'hA5A5_0440);

        repeat (2) @(posedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
